// File: rtl/branch_predictor.sv
// Direct-mapped branch history table: 2-bit saturating counters plus stored targets.
// Optional build macro BP_ALLOC_TAKEN_ONLY_EN: miss-updates allocate only for taken branches.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_IF,
  input  logic [31:0] PC_EX,
  input  logic        ID_EX_Branch,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic        BHT_hit,
  output logic        Predict_taken,
  output logic [31:0] Predict_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             ex_hit;

  logic             wr_en;
  logic [TAG_W-1:0] tag_d;
  logic [1:0]       cnt_d;
  logic [31:0]      tgt_d;

  assign idx_if = PC_IF[IDX_W+1:2];
  assign tag_if = PC_IF[31:IDX_W+2];
  assign idx_ex = PC_EX[IDX_W+1:2];
  assign tag_ex = PC_EX[31:IDX_W+2];

  // Combinational lookup sees pre-edge contents, so same-index updates appear next cycle.
  always_comb begin
    BHT_hit        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    Predict_taken  = 1'b0;
    Predict_target = 32'd0;
    if (BHT_hit) begin
      Predict_taken  = cnt_q[idx_if][1];
      Predict_target = tgt_q[idx_if];
    end
  end

  assign ex_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  // Next contents of the EX-indexed entry.
  always_comb begin
    wr_en = 1'b0;
    tag_d = tag_q[idx_ex];
    cnt_d = cnt_q[idx_ex];
    tgt_d = tgt_q[idx_ex];
    if (ID_EX_Branch) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        if (Branch_taken) begin
          if (cnt_q[idx_ex] != 2'b11) cnt_d = cnt_q[idx_ex] + 2'd1;
          tgt_d = Branch_target;
        end else if (cnt_q[idx_ex] != 2'b00) begin
          cnt_d = cnt_q[idx_ex] - 2'd1;
        end
      end else begin
`ifdef BP_ALLOC_TAKEN_ONLY_EN
        wr_en = Branch_taken;
`else
        wr_en = 1'b1;
`endif
        tag_d = tag_ex;
        cnt_d = Branch_taken ? 2'b10 : 2'b01;
        tgt_d = Branch_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
        tgt_q[i]   <= 32'd0;
      end
    end else if (wr_en) begin
      valid_q[idx_ex] <= 1'b1;
      tag_q[idx_ex]   <= tag_d;
      cnt_q[idx_ex]   <= cnt_d;
      tgt_q[idx_ex]   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan sequences plus random traffic vs. a table model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_IF, PC_EX, Branch_target;
  logic        ID_EX_Branch, Branch_taken;
  logic        BHT_hit, Predict_taken;
  logic [31:0] Predict_target;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    bit        v;
    bit [25:0] tag;
    int        ctr;
    bit [31:0] tgt;
  } ent_t;

  exp_t exp_q[$];
  ent_t model[16];

  branch_predictor dut (
    .clk(clk), .reset(reset), .PC_IF(PC_IF), .PC_EX(PC_EX),
    .ID_EX_Branch(ID_EX_Branch), .Branch_taken(Branch_taken), .Branch_target(Branch_target),
    .BHT_hit(BHT_hit), .Predict_taken(Predict_taken), .Predict_target(Predict_target)
  );

  always #5 clk = ~clk;

  function automatic int key_idx(input bit [31:0] key);
    return int'((key >> 2) % 32'd16);
  endfunction

  function automatic bit [25:0] key_tag(input bit [31:0] key);
    return 26'(key >> 6);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      model[i].v = 1'b0; model[i].tag = '0; model[i].ctr = 1; model[i].tgt = '0;
    end
  endfunction

  function automatic exp_t model_lookup(input bit [31:0] key);
    exp_t e;
    int i = key_idx(key);
    e = '0;
    if (model[i].v && model[i].tag == key_tag(key)) begin
      e.hit = 1'b1;
      e.tk  = (model[i].ctr >= 2);
      e.tgt = model[i].tgt;
    end
    return e;
  endfunction

  function automatic void model_update(input bit [31:0] key, input bit tk, input bit [31:0] tgt);
    int i = key_idx(key);
    if (model[i].v && model[i].tag == key_tag(key)) begin
      model[i].ctr = tk ? ((model[i].ctr + 1 > 3) ? 3 : model[i].ctr + 1)
                        : ((model[i].ctr - 1 < 0) ? 0 : model[i].ctr - 1);
      if (tk) model[i].tgt = tgt;
    end else begin
`ifdef BP_ALLOC_TAKEN_ONLY_EN
      if (!tk) return;
`endif
      model[i].v = 1'b1; model[i].tag = key_tag(key);
      model[i].ctr = tk ? 2 : 1; model[i].tgt = tgt;
    end
  endfunction

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got hit/tk/tgt=%h want %h at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus; expected lookup uses pre-edge model state, then the model advances.
  task automatic cyc(input bit [31:0] pif, input bit [31:0] pex, input bit br, input bit tk,
                     input bit [31:0] tgt);
    @(negedge clk);
    PC_IF = pif; PC_EX = pex; ID_EX_Branch = br; Branch_taken = tk; Branch_target = tgt;
    exp_q.push_back(model_lookup(pif));
    if (br && !reset) model_update(pex, tk, tgt);
  endtask

  // Monitor: the lookup is valid every cycle once inputs settle after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lookup", {BHT_hit, Predict_taken, Predict_target}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    PC_IF = '0; PC_EX = '0; ID_EX_Branch = 1'b0; Branch_taken = 1'b0; Branch_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    cyc(32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 check("reset_lookup", {BHT_hit, Predict_taken, Predict_target}, {2'b00, 32'h0});

    // Taken allocation then hit
    cyc(32'h10, 32'h10, 1'b1, 1'b1, 32'h40);
    cyc(32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 check("alloc_hit", {BHT_hit, Predict_taken, Predict_target}, {2'b11, 32'h40});
    cyc(32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 check("alias_miss", {BHT_hit, Predict_taken, Predict_target}, {2'b00, 32'h0});

    // Saturation walk: T x3, NT x4, T x2; NT targets must not overwrite
    for (int k = 0; k < 3; k++) cyc(32'h10, 32'h10, 1'b1, 1'b1, 32'h40);
    for (int k = 0; k < 4; k++) cyc(32'h10, 32'h10, 1'b1, 1'b0, 32'hDEAD_0000 + 32'(k));
    for (int k = 0; k < 2; k++) cyc(32'h10, 32'h10, 1'b1, 1'b1, 32'h44);
    cyc(32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 check("sat_recover", {BHT_hit, Predict_taken, Predict_target}, {2'b11, 32'h44});

    // Aliasing replacement by a not-taken branch
    cyc(32'h10, 32'h50, 1'b1, 1'b0, 32'h90);
    cyc(32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(32'h50, 32'h0, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and update of one index
    cyc(32'h20, 32'h20, 1'b1, 1'b1, 32'h80);
    #1 check("same_cycle_old", {BHT_hit, Predict_taken, Predict_target}, {2'b00, 32'h0});
    cyc(32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
    #1 check("same_cycle_new", {BHT_hit, Predict_taken, Predict_target}, {2'b11, 32'h80});

    // Asynchronous reset between edges, then a blocked update while reset is high
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1 check("async_reset", {BHT_hit, Predict_taken, Predict_target}, {2'b00, 32'h0});
    cyc(32'h20, 32'h20, 1'b1, 1'b1, 32'h84);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(model_lookup(32'h20));
    ID_EX_Branch = 1'b0;

    // Random traffic over a small key pool so hits, aliasing and saturation recur
    for (int n = 0; n < 600; n++) begin
      bit [31:0] kif, kex;
      kif = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom)};
      kex = {24'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) kex = kif;
      if ($urandom_range(0, 9) == 0) kex = 32'h0;
      cyc(kif, kex, 1'($urandom), 1'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch history table (BHT) with 2-bit saturating counters and stored branch targets.
- Sits beside the 5-stage pipeline CPU core.
- The IF stage looks it up combinationally to redirect fetch on a predicted-taken branch.
- The EX stage updates it once a conditional branch has resolved.
- All PCs presented to the block are "PC+4" values of the respective instruction. The block treats them as opaque keys.

Parameters:
- ENTRIES, 16, number of BHT entries; power of two, at least 2.
- IDX_W, log2(ENTRIES) = 4, index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- PC_IF  input  32  lookup key (PC+4 of the instruction in IF).
- PC_EX  input  32  update key (PC+4 of the instruction in EX).
- ID_EX_Branch  input  1  the instruction in EX is a conditional branch; enables update.
- Branch_taken  input  1  resolved branch outcome in EX.
- Branch_target  input  32  resolved taken-target in EX.
- BHT_hit  output  1  lookup found a valid entry whose tag matches.
- Predict_taken  output  1  predicted direction for PC_IF.
- Predict_target  output  32  predicted target for PC_IF.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Key split: index = key[IDX_W+1:2]; tag = key[31:IDX_W+2]. Bits [1:0] are ignored.
- Entry contents: valid (1 bit), tag (32-IDX_W-2 bits), counter (2 bits), target (32 bits).
- Lookup (purely combinational, no latency):
  - BHT_hit = valid[idx_IF] && tag[idx_IF] == tag(PC_IF).
  - On hit: Predict_taken = counter[1]; Predict_target = stored target.
  - On miss: Predict_taken = 0 and Predict_target = 0.
- Update: happens on the rising clk edge only when ID_EX_Branch = 1 and reset = 0.
  - Hit at idx_EX (valid and tag matches):
    - Counter increments saturating at 3 if Branch_taken, else decrements saturating at 0.
    - If Branch_taken, target <= Branch_target; otherwise the target is unchanged.
  - Miss (invalid entry or tag mismatch): allocate or replace.
    - valid <= 1, tag <= tag(PC_EX), target <= Branch_target.
    - Counter <= 2'b10 if taken, else 2'b01.
- When ID_EX_Branch = 0, no state changes; Branch_taken and Branch_target are don't-care.
- Simultaneous lookup and update of the same index: lookup returns the pre-edge (old) contents. The new value is visible from the next cycle.
- Reset (asynchronous, any time including mid-update): all valid = 0, counters = 2'b01, tags = 0, targets = 0. Outputs immediately become BHT_hit = 0, Predict_taken = 0, Predict_target = 0.
- Key 0 (flushed pipeline bubble) is handled like any key. An update with key 0 occurs only if ID_EX_Branch = 1.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Optional Feature:
- Macro: BP_ALLOC_TAKEN_ONLY_EN.
- Defined: a miss-update allocates only when Branch_taken = 1. A not-taken branch that misses leaves the entry (including any aliasing entry) untouched.
- Undefined: every resolved branch allocates on a miss, as described above.
- Hit-update behaviour is identical in both builds.

Test Plan:
- Reset, then PC_IF = 0x00000010 -> BHT_hit = 0, Predict_taken = 0, Predict_target = 0.
- One update with PC_EX = 0x00000010, taken, target 0x00000040; then PC_IF = 0x00000010 -> hit = 1, taken = 1, target = 0x00000040.
  - Same setup, then PC_IF = 0x00000050 (same index, different tag) -> hit = 0.
- Saturation on key 0x00000010 (starting from the taken allocation):
  - Three further taken updates -> counter 3.
  - Then NT, NT -> Predict_taken = 0 (counter 1).
  - Two more NT -> counter stays 0 (Predict_taken = 0).
  - Two taken -> Predict_taken = 1.
  - Target is unchanged by NT updates.
- Aliasing: entry for 0x00000010 taken; update PC_EX = 0x00000050 not-taken -> PC_IF = 0x00000010 misses, PC_IF = 0x00000050 hits with taken = 0.
  - With BP_ALLOC_TAKEN_ONLY_EN defined: 0x00000010 still hits and 0x00000050 misses.
- Same-cycle read/write: PC_IF = PC_EX = 0x00000020 with an update pending -> outputs reflect old state that cycle and new state the next cycle.
- Assert reset asynchronously between clock edges while entries are valid -> BHT_hit drops to 0 immediately.
  - No update occurs on the following edge while reset is high.
